misc_drain_arb: RTL
===================

# misc_drain_arb

Round-robin drain scheduler that shares the DPL buffer write port between several misc FIFOs. Each FIFO advertises a burst-ready request (≥16 entries) and its almost-empty flag. The arbiter grants one FIFO at a time, issues up to BURST_LEN pops, collects the returned data beats and forwards them to the DPL buffer with start/end-of-burst framing. It sits in the PCIe clock domain, on the read side of the misc FIFOs.

## Interface
- NUM_REQ, 4: number of misc FIFO requesters (2..8).
- BURST_LEN, 16: maximum pops per grant (power of 2, ≤64).
- DATA_W, 256: data beat width.
- DRAIN_TO, 7: idle cycles allowed in DRAIN before abort.
- iCLK  in  1  clock; single clock domain.
- iRST_N  in  1  reset; asynchronous assert, active-low.
- iREQ  in  NUM_REQ  per-FIFO burst-ready (the FIFO's RD_REQ).
- iAEMPTY  in  NUM_REQ  per-FIFO almost-empty; a pop is legal only while low.
- iDATA  in  NUM_REQ*DATA_W  per-FIFO read data; slice i = [i*DATA_W +: DATA_W].
- iDATA_V  in  NUM_REQ  per-FIFO data valid; asserts 1 cycle after a pop.
- iDPL_AFULL  in  1  DPL buffer almost full; stalls pops.
- oPOP  out  NUM_REQ  pop strobe to FIFO i (one-hot or zero).
- oDPL_DATA  out  DATA_W  forwarded beat.
- oDPL_DATA_V  out  1  beat valid.
- oDPL_SRC  out  $clog2(NUM_REQ)  source index of the current beat.
- oDPL_SOB / oDPL_EOB  out  1 each  first / last beat of a burst.
- oBUSY  out  1  state ≠ IDLE.
- oERR  out  1  1-cycle pulse on a DRAIN timeout.

## Operation
- The FSM has three states: IDLE, POP, DRAIN.
- **IDLE**
  - Eligible set = iREQ & ~iAEMPTY.
  - If the set is non-empty, pick the first eligible index at or after rr_ptr (wrapping), register it as grant, clear pop_cnt and beat_cnt, and go to POP.
  - rr_ptr ← grant+1 mod NUM_REQ at the moment of the grant.
- **POP**
  - oPOP[grant] = ~iAEMPTY[grant] & ~iDPL_AFULL. This term is combinational from the registered state and grant.
  - Each pop increments pop_cnt.
  - Go to DRAIN when:
    - a pop occurs with pop_cnt == BURST_LEN-1, or
    - iAEMPTY[grant] is high (short burst).
  - While iDPL_AFULL is high, pops pause and the FSM stays in POP.
- **Zero pops**: if the first POP cycle has iAEMPTY[grant] high and pop_cnt == 0, go straight to IDLE. No beats are produced.
- **DRAIN**
  - Return to IDLE when beat_cnt == pop_cnt.
  - If DRAIN_TO consecutive cycles pass without iDATA_V[grant], return to IDLE and pulse oERR.
- **Beat collection** (in POP and DRAIN): when iDATA_V[grant] is high, register oDPL_DATA ← iDATA slice[grant], oDPL_DATA_V ← 1, oDPL_SRC ← grant, and increment beat_cnt.
  - oDPL_SOB = (beat_cnt == 0) at capture.
  - oDPL_EOB = at capture, the FSM is in DRAIN or is leaving POP, and beat_cnt+1 == pop_cnt (post-update).
- iDATA_V from any non-granted source is ignored.
- Counters are $clog2(BURST_LEN)+1 bits wide, with no wrap inside a burst.

## Timing
- **Latency**
  - Grant: 1 cycle after eligibility is seen in IDLE.
  - First oPOP: the first POP cycle.
  - Beat: iDATA_V → oDPL_DATA_V is 1 cycle.
- **Throughput**: one pop per cycle. A full 16-beat burst occupies 1 IDLE + 16 POP + 1–2 DRAIN cycles.
- **Reset values**: all outputs are 0, state = IDLE, rr_ptr = 0, counters = 0, grant = 0.
- **Reset mid-burst**: reset asserted mid-burst drops everything immediately. No EOB is generated.
- **Simultaneous events**
  - iAEMPTY and iDPL_AFULL high together: no pop; AEMPTY wins and the FSM moves to DRAIN.
  - A new iREQ while busy is held until IDLE.

## Structure
- Package misc_drain_pkg holds:
  - the state enum (IDLE, POP, DRAIN);
  - the default constants BURST_LEN_DEF and DRAIN_TO_DEF.
- One sub-module, misc_rr_pick. It is a combinational round-robin first-set finder that takes (eligible vector, rr_ptr) and returns (index, found).

## Test plan
- **Single full burst**: iREQ[2]=1, iAEMPTY=0, AFULL=0 → exactly 16 oPOP[2] pulses on consecutive cycles, then 16 beats with SOB on beat 0, EOB on beat 15, oDPL_SRC=2. oBUSY drops 1 cycle after EOB.
- **Round-robin**: iREQ=4'b1111 held for 4 bursts → grant order 0,1,2,3. Next, with iREQ=4'b1001 after grant 3 → grant 0.
- **Short burst**: iAEMPTY[1] rises after 5 pops → exactly 5 beats, EOB on beat 4, return to IDLE.
- **Backpressure**: iDPL_AFULL high for 3 cycles mid-burst → oPOP pauses for those cycles, total pops still 16, beats remain contiguous in order.
- **Timeout and reset**:
  - Suppress iDATA_V after 10 pops → oERR pulses once 7 cycles into DRAIN, then state = IDLE.
  - Assert iRST_N low mid-POP → all outputs go to 0 that cycle, rr_ptr = 0.
- **Zero-pop / spurious**:
  - Grant followed immediately by iAEMPTY high → no oPOP, no beats.
  - iDATA_V[3] while grant=0 → no oDPL_DATA_V.

Source files
------------

// File: rtl/misc_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misc_drain_pkg
// Description : Shared state encoding and default constants for the misc FIFO
//               drain arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package misc_drain_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default maximum pops per grant
  localparam int BURST_LEN_DEF = 16;
  // Default idle cycles tolerated in DRAIN before giving up on the burst
  localparam int DRAIN_TO_DEF  = 7;

endpackage
`default_nettype wire

// File: rtl/misc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : misc_rr_pick
// Description : Combinational round-robin first-set finder. Returns the first
//               set bit of the eligible vector at or after rrPtr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module misc_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rrPtr,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       found
);

  localparam int SW = $clog2(NUM_REQ);

  logic [SW-1:0] wIdxHi;
  logic [SW-1:0] wIdxAll;
  logic          wFoundHi;
  logic          wFoundAll;

  // Lowest eligible index at/above the pointer, else lowest overall (wrap)
  always_comb begin
    wIdxHi    = '0;
    wIdxAll   = '0;
    wFoundHi  = 1'b0;
    wFoundAll = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        wIdxAll   = SW'(i);
        wFoundAll = 1'b1;
        if (i >= int'(rrPtr)) begin
          wIdxHi   = SW'(i);
          wFoundHi = 1'b1;
        end
      end
    end
    index = wFoundHi ? wIdxHi : wIdxAll;
    found = wFoundAll;
  end

endmodule
`default_nettype wire

// File: rtl/misc_drain_arb.sv
`default_nettype none
// ============================================================================
// Module      : misc_drain_arb
// Description : Round-robin drain scheduler sharing the DPL buffer write port
//               between misc FIFOs. Grants one FIFO, pops up to BURST_LEN
//               entries, and forwards returned beats with SOB/EOB framing.
// Revision    : 1.0 - initial release
// ============================================================================
module misc_drain_arb
  import misc_drain_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int DATA_W    = 256,
  parameter int DRAIN_TO  = DRAIN_TO_DEF
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [NUM_REQ-1:0]         iREQ,
  input  logic [NUM_REQ-1:0]         iAEMPTY,
  input  logic [NUM_REQ*DATA_W-1:0]  iDATA,
  input  logic [NUM_REQ-1:0]         iDATA_V,
  input  logic                       iDPL_AFULL,
  output logic [NUM_REQ-1:0]         oPOP,
  output logic [DATA_W-1:0]          oDPL_DATA,
  output logic                       oDPL_DATA_V,
  output logic [$clog2(NUM_REQ)-1:0] oDPL_SRC,
  output logic                       oDPL_SOB,
  output logic                       oDPL_EOB,
  output logic                       oBUSY,
  output logic                       oERR
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int TW = $clog2(DRAIN_TO) + 1;

  localparam logic [CW-1:0] cLastPop = CW'(BURST_LEN - 1);
  localparam logic [TW-1:0] cToLast  = TW'(DRAIN_TO - 1);

  state_t        rState;
  logic [SW-1:0] rGrant;
  logic [SW-1:0] rRrPtr;
  logic [CW-1:0] rPopCnt;
  logic [CW-1:0] rBeatCnt;
  logic [TW-1:0] rIdleCnt;

  logic [DATA_W-1:0] rDplData;
  logic              rDplDataV;
  logic [SW-1:0]     rDplSrc;
  logic              rDplSob;
  logic              rDplEob;
  logic              rErr;

  logic [DATA_W-1:0] wDataArr [NUM_REQ];
  logic [NUM_REQ-1:0] wElig;
  logic [SW-1:0]     wPickIdx;
  logic              wPickFound;
  logic [SW-1:0]     wNextPtr;
  logic              wAemptyG;
  logic              wDataVG;
  logic              wPop;
  logic              wLastPop;
  logic              wLeavePop;
  logic              wCollect;
  logic [CW-1:0]     wPopCntNext;
  logic [CW-1:0]     wBeatCntInc;

  // Per-FIFO view of the flattened read-data bus
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign wDataArr[gi] = iDATA[gi*DATA_W +: DATA_W];
  end

  assign wElig    = iREQ & ~iAEMPTY;
  assign wNextPtr = (wPickIdx == SW'(NUM_REQ - 1)) ? '0 : wPickIdx + SW'(1);

  misc_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (wElig),
    .rrPtr    (rRrPtr),
    .index    (wPickIdx),
    .found    (wPickFound)
  );

  assign wAemptyG    = iAEMPTY[rGrant];
  assign wDataVG     = iDATA_V[rGrant];
  // Almost-empty takes priority over backpressure: no pop when either is high
  assign wPop        = (rState == POP) && !wAemptyG && !iDPL_AFULL;
  assign wLastPop    = wPop && (rPopCnt == cLastPop);
  assign wLeavePop   = (rState == POP) && (wAemptyG || wLastPop);
  assign wPopCntNext = wPop ? rPopCnt + CW'(1) : rPopCnt;
  assign wBeatCntInc = rBeatCnt + CW'(1);
  // Beats are only accepted from the granted FIFO while a burst is open
  assign wCollect    = wDataVG &&
                       ((rState == POP) || ((rState == DRAIN) && (rBeatCnt != rPopCnt)));

  // Pop strobe to the granted FIFO, decoded from registered state
  always_comb begin
    oPOP = '0;
    if (wPop) oPOP[rGrant] = 1'b1;
  end

  // Arbiter FSM, counters and registered beat outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rState    <= IDLE;
      rGrant    <= '0;
      rRrPtr    <= '0;
      rPopCnt   <= '0;
      rBeatCnt  <= '0;
      rIdleCnt  <= '0;
      rDplData  <= '0;
      rDplDataV <= 1'b0;
      rDplSrc   <= '0;
      rDplSob   <= 1'b0;
      rDplEob   <= 1'b0;
      rErr      <= 1'b0;
    end else begin
      rErr      <= 1'b0;
      rDplDataV <= 1'b0;
      rDplSob   <= 1'b0;
      rDplEob   <= 1'b0;

      case (rState)
        IDLE: begin
          if (wPickFound) begin
            rGrant   <= wPickIdx;
            rRrPtr   <= wNextPtr;
            rPopCnt  <= '0;
            rBeatCnt <= '0;
            rState   <= POP;
          end
        end
        POP: begin
          rIdleCnt <= '0;
          rPopCnt  <= wPopCntNext;
          if (wAemptyG) begin
            // Nothing popped yet means nothing to drain
            rState <= (rPopCnt == '0) ? IDLE : DRAIN;
          end else if (wLastPop) begin
            rState <= DRAIN;
          end
        end
        DRAIN: begin
          if (rBeatCnt == rPopCnt) begin
            rState <= IDLE;
          end else if (wDataVG) begin
            rIdleCnt <= '0;
          end else if (rIdleCnt == cToLast) begin
            rState <= IDLE;
            rErr   <= 1'b1;
          end else begin
            rIdleCnt <= rIdleCnt + TW'(1);
          end
        end
        default: rState <= IDLE;
      endcase

      if (wCollect) begin
        rBeatCnt  <= wBeatCntInc;
        rDplData  <= wDataArr[rGrant];
        rDplDataV <= 1'b1;
        rDplSrc   <= rGrant;
        rDplSob   <= (rBeatCnt == '0);
        rDplEob   <= ((rState == DRAIN) || wLeavePop) && (wBeatCntInc == wPopCntNext);
      end
    end
  end

  assign oDPL_DATA   = rDplData;
  assign oDPL_DATA_V = rDplDataV;
  assign oDPL_SRC    = rDplSrc;
  assign oDPL_SOB    = rDplSob;
  assign oDPL_EOB    = rDplEob;
  assign oERR        = rErr;
  assign oBUSY       = (rState != IDLE);

endmodule
`default_nettype wire
